// File: rtl/sc_collatz_monitor.sv
// Observer for the Collatz datapath result bus: latches the seed and checks every
// bus transition against one Collatz step (mod 2^DATAWIDTH_BUS). It reports steps, peak and a status.
module sc_collatz_monitor #(
  parameter int DATAWIDTH_BUS     = 8,
  parameter int DATAWIDTH_TIMEOUT = 8,
  parameter int TIMEOUT_CYCLES    = 200
) (
  input  logic                     SC_COLLATZMONITOR_CLOCK_50,
  input  logic                     SC_COLLATZMONITOR_RESET_InLow,
  input  logic                     SC_COLLATZMONITOR_start_InLow,
  input  logic [DATAWIDTH_BUS-1:0] SC_COLLATZMONITOR_seed_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] SC_COLLATZMONITOR_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_COLLATZMONITOR_steps_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_COLLATZMONITOR_peak_OutBUS,
  output logic                     SC_COLLATZMONITOR_busy_OutLow,
  output logic                     SC_COLLATZMONITOR_done_OutLow,
  output logic                     SC_COLLATZMONITOR_error_OutLow,
  output logic [1:0]               SC_COLLATZMONITOR_errorcode_OutBUS
);

  localparam int W  = DATAWIDTH_BUS;
  localparam int T  = DATAWIDTH_TIMEOUT;
  localparam int XW = DATAWIDTH_BUS + 2;
  localparam logic [W-1:0] ONE         = W'(1);
  localparam logic [W-1:0] STEPS_MAX   = '1;
  localparam logic [T-1:0] STALL_ONE   = T'(1);
  localparam logic [T-1:0] TIMEOUT_VAL = T'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WAIT_SEED, TRACK, DONE, ERROR} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   seed_q, seed_d;
  logic [W-1:0]   prev_q, prev_d;
  logic [W-1:0]   steps_q, steps_d;
  logic [W-1:0]   peak_q, peak_d;
  logic [T-1:0]   stall_q, stall_d;
  logic [1:0]     code_q, code_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic [XW-1:0]  triple;
  logic [W-1:0]   expected;
  logic [T-1:0]   stall_inc;

  // 3*prev+1 is formed two bits wider than the bus, then truncated (wraps mod 2^W).
  assign triple    = XW'({prev_q, 1'b0}) + XW'(prev_q) + XW'(1);
  assign expected  = prev_q[0] ? triple[W-1:0] : {1'b0, prev_q[W-1:1]};
  assign stall_inc = stall_q + STALL_ONE;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    prev_d  = prev_q;
    steps_d = steps_q;
    peak_d  = peak_q;
    stall_d = stall_q;
    code_d  = code_q;

    if (!SC_COLLATZMONITOR_start_InLow) begin
      seed_d  = SC_COLLATZMONITOR_seed_InBUS;
      steps_d = '0;
      peak_d  = '0;
      stall_d = '0;
      code_d  = 2'b00;
      if (SC_COLLATZMONITOR_seed_InBUS == '0) begin
        state_d = ERROR;
        code_d  = 2'b01;
      end else begin
        state_d = WAIT_SEED;
      end
    end else begin
      case (state_q)
        WAIT_SEED: begin
          if (SC_COLLATZMONITOR_data_InBUS == seed_q) begin
            if (seed_q == ONE) begin
              state_d = DONE;
              steps_d = '0;
              peak_d  = ONE;
            end else begin
              state_d = TRACK;
              prev_d  = seed_q;
              peak_d  = seed_q;
              stall_d = '0;
            end
          end
        end
        TRACK: begin
          if (SC_COLLATZMONITOR_data_InBUS == prev_q) begin
            stall_d = stall_inc;
            if (stall_inc == TIMEOUT_VAL) begin
              state_d = ERROR;
              code_d  = 2'b11;
            end
          end else if (SC_COLLATZMONITOR_data_InBUS == expected) begin
            prev_d  = SC_COLLATZMONITOR_data_InBUS;
            steps_d = (steps_q == STEPS_MAX) ? steps_q : steps_q + ONE;
            if (SC_COLLATZMONITOR_data_InBUS > peak_q) peak_d = SC_COLLATZMONITOR_data_InBUS;
            stall_d = '0;
            if (SC_COLLATZMONITOR_data_InBUS == ONE) state_d = DONE;
          end else begin
            state_d = ERROR;
            code_d  = 2'b10;
          end
        end
        default: ;
      endcase
    end

    // Status flags are decoded from the next state so they change on the same edge.
    busy_d  = !((state_d == WAIT_SEED) || (state_d == TRACK));
    done_d  = (state_d != DONE);
    error_d = (state_d != ERROR);
  end

  always_ff @(posedge SC_COLLATZMONITOR_CLOCK_50) begin
    if (!SC_COLLATZMONITOR_RESET_InLow) begin
      state_q <= IDLE;
      seed_q  <= '0;
      prev_q  <= '0;
      steps_q <= '0;
      peak_q  <= '0;
      stall_q <= '0;
      code_q  <= 2'b00;
      busy_q  <= 1'b1;
      done_q  <= 1'b1;
      error_q <= 1'b1;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      prev_q  <= prev_d;
      steps_q <= steps_d;
      peak_q  <= peak_d;
      stall_q <= stall_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign SC_COLLATZMONITOR_steps_OutBUS     = steps_q;
  assign SC_COLLATZMONITOR_peak_OutBUS      = peak_q;
  assign SC_COLLATZMONITOR_busy_OutLow      = busy_q;
  assign SC_COLLATZMONITOR_done_OutLow      = done_q;
  assign SC_COLLATZMONITOR_error_OutLow     = error_q;
  assign SC_COLLATZMONITOR_errorcode_OutBUS = code_q;

endmodule

// File: tb/tb_sc_collatz_monitor.sv
// Bench for sc_collatz_monitor: directed scenarios plus randomized runs, every cycle
// compared against an arithmetic reference model of the monitor's rules.
module tb_sc_collatz_monitor;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst_n, start_n;
  logic [7:0] seed_in, data_in;
  logic [7:0] steps_o, peak_o;
  logic       busy_o, done_o, error_o;
  logic [1:0] code_o;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 waiting for seed, 2 tracking, 3 done, 4 error.
  int m_phase, m_seed, m_prev, m_steps, m_peak, m_stall, m_code;

  always #10 clk = ~clk;

  sc_collatz_monitor #(.DATAWIDTH_BUS(8), .DATAWIDTH_TIMEOUT(8), .TIMEOUT_CYCLES(TO)) dut (
    .SC_COLLATZMONITOR_CLOCK_50        (clk),
    .SC_COLLATZMONITOR_RESET_InLow     (rst_n),
    .SC_COLLATZMONITOR_start_InLow     (start_n),
    .SC_COLLATZMONITOR_seed_InBUS      (seed_in),
    .SC_COLLATZMONITOR_data_InBUS      (data_in),
    .SC_COLLATZMONITOR_steps_OutBUS    (steps_o),
    .SC_COLLATZMONITOR_peak_OutBUS     (peak_o),
    .SC_COLLATZMONITOR_busy_OutLow     (busy_o),
    .SC_COLLATZMONITOR_done_OutLow     (done_o),
    .SC_COLLATZMONITOR_error_OutLow    (error_o),
    .SC_COLLATZMONITOR_errorcode_OutBUS(code_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int collatz_next(input int p);
    return (p % 2 == 0) ? p / 2 : (3 * p + 1) % 256;
  endfunction

  task automatic model_edge(input logic r, input logic s, input int sd, input int d);
    if (!r) begin
      m_phase = 0; m_seed = 0; m_prev = 0; m_steps = 0; m_peak = 0; m_stall = 0; m_code = 0;
    end else if (!s) begin
      m_seed = sd; m_steps = 0; m_peak = 0; m_stall = 0; m_code = 0;
      if (sd == 0) begin m_phase = 4; m_code = 1; end
      else m_phase = 1;
    end else if (m_phase == 1) begin
      if (d == m_seed) begin
        if (m_seed == 1) begin m_phase = 3; m_steps = 0; m_peak = 1; end
        else begin m_phase = 2; m_prev = m_seed; m_peak = m_seed; m_stall = 0; end
      end
    end else if (m_phase == 2) begin
      if (d == m_prev) begin
        m_stall++;
        if (m_stall == TO) begin m_phase = 4; m_code = 3; end
      end else if (d == collatz_next(m_prev)) begin
        m_prev = d;
        m_steps = (m_steps < 255) ? m_steps + 1 : 255;
        if (d > m_peak) m_peak = d;
        m_stall = 0;
        if (d == 1) m_phase = 3;
      end else begin
        m_phase = 4; m_code = 2;
      end
    end
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, compare at the next falling edge.
  task automatic tick(input logic r, input logic s, input logic [7:0] sd, input logic [7:0] d);
    rst_n = r; start_n = s; seed_in = sd; data_in = d;
    @(posedge clk);
    model_edge(r, s, int'(sd), int'(d));
    @(negedge clk);
    check("steps", 32'(steps_o), 32'(m_steps));
    check("peak",  32'(peak_o),  32'(m_peak));
    check("busy",  32'(busy_o),  (m_phase == 1 || m_phase == 2) ? 32'd0 : 32'd1);
    check("done",  32'(done_o),  (m_phase == 3) ? 32'd0 : 32'd1);
    check("error", 32'(error_o), (m_phase == 4) ? 32'd0 : 32'd1);
    check("code",  32'(code_o),  32'(m_code));
  endtask

  task automatic start_seed(input logic [7:0] sd);
    tick(1'b1, 1'b0, sd, 8'h00);
  endtask

  task automatic bus(input logic [7:0] v, input int hold);
    for (int i = 0; i < hold; i++) tick(1'b1, 1'b1, 8'h00, v);
  endtask

  task automatic show(input string name);
    $display("%s: seed %0d steps %0d peak %0d busy %0b done %0b error %0b code %0d",
             name, m_seed, steps_o, peak_o, busy_o, done_o, error_o, code_o);
  endtask

  initial begin
    int v, sd, hold, ev;
    logic [7:0] seq6 [9];
    seq6 = '{8'd6, 8'd3, 8'd10, 8'd5, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};

    rst_n = 1'b0; start_n = 1'b1; seed_in = '0; data_in = '0;
    tick(1'b0, 1'b1, 8'h00, 8'h00);
    tick(1'b0, 1'b0, 8'h05, 8'h05);
    check("rst_steps", 32'(steps_o), 32'd0);
    check("rst_flags", {29'd0, busy_o, done_o, error_o}, 32'd7);
    show("reset");

    // Seed 6, each value held three cycles
    start_seed(8'd6);
    check("arm_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 9; i++) bus(seq6[i], 3);
    check("s6_done", 32'(done_o), 32'd0);
    check("s6_steps", 32'(steps_o), 32'd8);
    check("s6_peak", 32'(peak_o), 32'd16);
    check("s6_code", 32'(code_o), 32'd0);
    show("seed6");

    // Wrapping step: 3*171+1 = 514 -> 2
    start_seed(8'd171);
    bus(8'd171, 1); bus(8'd2, 1); bus(8'd1, 1);
    check("s171_done", 32'(done_o), 32'd0);
    check("s171_steps", 32'(steps_o), 32'd2);
    check("s171_peak", 32'(peak_o), 32'd171);
    show("seed171");

    // Bad step
    start_seed(8'd6);
    bus(8'd6, 1); bus(8'd4, 1);
    check("bad_error", 32'(error_o), 32'd0);
    check("bad_code", 32'(code_o), 32'd2);
    check("bad_steps", 32'(steps_o), 32'd0);
    check("bad_peak", 32'(peak_o), 32'd6);
    show("badstep");

    // Timeout exactly at the TO-th stalled TRACK edge
    start_seed(8'd6);
    bus(8'd6, 1);
    bus(8'd6, TO - 1);
    check("to_before", 32'(error_o), 32'd1);
    bus(8'd6, 1);
    check("to_error", 32'(error_o), 32'd0);
    check("to_code", 32'(code_o), 32'd3);
    show("timeout");

    // Illegal seed, then trivial seed 1
    start_seed(8'd0);
    check("zero_error", 32'(error_o), 32'd0);
    check("zero_code", 32'(code_o), 32'd1);
    start_seed(8'd1);
    bus(8'd1, 1);
    check("one_done", 32'(done_o), 32'd0);
    check("one_peak", 32'(peak_o), 32'd1);
    check("one_code", 32'(code_o), 32'd0);
    show("seed0_then_1");

    // Reset mid-run, then a clean restart
    start_seed(8'd6);
    bus(8'd6, 1); bus(8'd3, 1); bus(8'd10, 1);
    tick(1'b0, 1'b1, 8'h00, 8'd5);
    check("mid_rst_steps", 32'(steps_o), 32'd0);
    check("mid_rst_peak", 32'(peak_o), 32'd0);
    check("mid_rst_flags", {29'd0, busy_o, done_o, error_o}, 32'd7);
    start_seed(8'd6);
    for (int i = 0; i < 9; i++) bus(seq6[i], 1);
    check("rerun_steps", 32'(steps_o), 32'd8);
    show("reset_restart");

    // Restart during TRACK, start held low for several cycles
    start_seed(8'd6);
    bus(8'd6, 1); bus(8'd3, 1);
    start_seed(8'd5); start_seed(8'd5);
    tick(1'b1, 1'b0, 8'd5, 8'd5);
    check("restart_code", 32'(code_o), 32'd0);
    for (int i = 3; i < 9; i++) bus(seq6[i], 1);
    check("restart_steps", 32'(steps_o), 32'd5);
    check("restart_peak", 32'(peak_o), 32'd16);
    show("restart");

    // Randomized runs: legal trajectories with occasional glitches, restarts, resets and stalls
    for (int run = 0; run < 60; run++) begin
      ev = $urandom_range(0, 19);
      if (ev == 0) sd = 0;
      else if (ev == 1) sd = 1;
      else if (ev == 2) sd = 85;
      else sd = $urandom_range(1, 255);
      for (int i = 0, n = $urandom_range(1, 2); i < n; i++)
        tick(1'b1, 1'b0, 8'(sd), 8'($urandom_range(0, 255)));
      bus(8'(sd) ^ 8'h80, $urandom_range(0, 3));
      v = sd;
      for (int k = 0; k < 80; k++) begin
        hold = ($urandom_range(0, 59) == 0) ? TO + 2 : $urandom_range(1, 3);
        bus(8'(v), hold);
        ev = $urandom_range(0, 99);
        if (ev < 3) begin
          bus(8'(v) ^ 8'($urandom_range(1, 255)), 2);
          break;
        end else if (ev < 5) begin
          break;
        end else if (ev < 7) begin
          tick(1'b0, 1'b1, 8'h00, 8'(v));
          break;
        end
        if (v == 1 || v == 0) break;
        v = collatz_next(v);
      end
      bus(8'($urandom_range(0, 255)), 1);
      $display("run %0d: seed %0d steps %0d peak %0d code %0d", run, sd, m_steps, m_peak, m_code);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
